// File: rtl/lfsr_prng_if.sv
// Handshake and control bundle for the LFSR pseudo-random generator.
// The master side drives the control and seed inputs; the slave side
// is the generator itself.
interface lfsr_prng_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             acquire_seed;
  logic [WIDTH-1:0] seed;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] rng_out;
  logic             seed_fixed;
  logic             busy;

  modport master (
    output en, acquire_seed, seed, out_ready,
    input  out_valid, rng_out, seed_fixed, busy
  );

  modport slave (
    input  en, acquire_seed, seed, out_ready,
    output out_valid, rng_out, seed_fixed, busy
  );
endinterface

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR pseudo-random generator.
// Each accepted word advances the state by STEPS chained shifts in a single
// cycle. After reset or a seed load, WARMUP words are discarded before
// out_valid rises. A zero seed is replaced by ZERO_FIX so the state never
// locks up at zero.
module lfsr_prng #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(32'hD000_0001),
  parameter int               STEPS      = 1,
  parameter int               WARMUP     = 0,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter logic [WIDTH-1:0] ZERO_FIX   = WIDTH'(1)
) (
  input logic        clk,
  input logic        rst,
  lfsr_prng_if.slave bus
);

  localparam logic [0:0]  ST_WARM   = 1'b0;
  localparam logic [0:0]  ST_RUN    = 1'b1;
  localparam logic [0:0]  ST_INIT   = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam logic [15:0] WARM_INIT = 16'(WARMUP);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic [0:0]       fsm;
  logic [15:0]      warm_cnt;
  logic             seed_fixed_q;
  logic             advance;

  // STEPS chained Fibonacci shifts: feedback is the parity of the tapped bits,
  // shifted in at the LSB.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = s;
    for (int i = 0; i < STEPS; i++) begin
      fb = ^(r & TAPS);
      r  = {r[WIDTH-2:0], fb};
    end
    return r;
  endfunction

  // Decide whether this cycle advances: every enabled WARM cycle, or an
  // enabled RUN cycle where the consumer takes the word.
  always_comb begin
    next_state = lfsr_step(state);
    advance    = 1'b0;
    if (bus.en) begin
      advance = (fsm == ST_WARM) || bus.out_ready;
    end
  end

  // State, warm-up counter and FSM; a seed load overrides any advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RESET_SEED;
      fsm          <= ST_INIT;
      warm_cnt     <= WARM_INIT;
      seed_fixed_q <= 1'b0;
    end else begin
      seed_fixed_q <= 1'b0;
      if (bus.acquire_seed) begin
        state        <= (bus.seed == '0) ? ZERO_FIX : bus.seed;
        seed_fixed_q <= (bus.seed == '0);
        fsm          <= ST_INIT;
        warm_cnt     <= WARM_INIT;
      end else if (advance) begin
        state <= next_state;
        if (fsm == ST_WARM) begin
          warm_cnt <= warm_cnt - 16'd1;
          if (warm_cnt == 16'd1) begin
            fsm <= ST_RUN;
          end
        end
      end
    end
  end

  assign bus.rng_out    = state;
  assign bus.out_valid  = (fsm == ST_RUN);
  assign bus.busy       = (fsm == ST_WARM);
  assign bus.seed_fixed = seed_fixed_q;

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
Parametrised Fibonacci LFSR pseudo-random generator and the next generation of the team's 32-bit LFSR. It adds configurable width and taps, multi-step advance per output word, and zero-seed protection. A warm-up discard phase and a valid/ready output handshake let it feed key/nonce generation logic in the RSA datapath directly.

Parameters:
WIDTH, 32, state and output width in bits (>=3).
TAPS, 32'hD000_0001, feedback mask; bit i set => state bit i is XORed into feedback (default = taps 32,31,29,1).
STEPS, 1, LFSR shifts applied per accepted word (1..WIDTH).
WARMUP, 0, words (each STEPS shifts) discarded after reset or seed load before out_valid rises (0..65535).
RESET_SEED, 1, state value loaded by reset (must be non-zero).
ZERO_FIX, 1, non-zero substitute loaded when seed==0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  global enable; 0 freezes state, FSM and warm-up counter.
acquire_seed  in  1  load seed this cycle (ignores en).
seed  in  WIDTH  new seed value.
out_ready  in  1  consumer accepts rng_out.
out_valid  out  1  rng_out holds a fresh word.
rng_out  out  WIDTH  current LFSR state.
seed_fixed  out  1  one-cycle pulse: last acquire_seed carried seed==0.
busy  out  1  high while in WARM.

Behaviour:
- Single shift: fb = XOR of s[i] for all i with TAPS[i]=1; s_next = {s[WIDTH-2:0], fb}. One "step" = STEPS chained shifts, computed combinationally in one cycle.
- rng_out is wired to the state register; no extra latency.
- FSM states WARM and RUN.
- Reset (rst=0, async): state<=RESET_SEED, seed_fixed<=0, warm counter<=WARMUP. FSM<=RUN if WARMUP==0, else WARM. out_valid = (FSM==RUN), so 1 after reset when WARMUP==0. busy=(FSM==WARM).
- acquire_seed=1 (any state, regardless of en or out_ready): state<=(seed==0 ? ZERO_FIX : seed). seed_fixed<=(seed==0) for exactly one cycle. Counter and FSM are reinitialised exactly as at reset. Load has priority over every other action in that cycle; no advance occurs.
- WARM, en=1: state advances one step per cycle and the counter decrements. When it hits 0 the FSM goes to RUN on the same edge, so out_valid rises WARMUP cycles after load. out_ready is ignored in WARM.
- RUN, en=1: handshake completes when out_valid && out_ready; the state advances one step on that edge. Without acceptance, rng_out holds stable (no skipped words). Back-to-back accepts yield a new word every cycle.
- en=0: no state, counter or FSM change. out_valid keeps its value; a completed handshake with en=0 does not advance (consumer sees the same word again). seed load still works.
- The state can never become 0 (reset/seed guards, and taps must form a valid polynomial); no runtime check beyond seed substitution.
- Reset mid-warm-up or mid-handshake: async reset overrides immediately; the in-flight word is dropped.

Test Plan:
- Reset, WARMUP=0, default taps: out_valid=1 and rng_out=0x00000001 right after reset release. Three accepts -> 0x00000003, 0x00000007, 0x0000000F.
- acquire_seed with seed=0 -> rng_out=0x00000001 (ZERO_FIX), seed_fixed high exactly one cycle. acquire_seed with seed=0x80000000 -> next accept gives 0x00000001 (fb=s[31]=1).
- WARMUP=4, seed=1 load: busy=1 and out_valid=0 for 4 cycles. Then out_valid=1 with rng_out=0x0000001F.
- out_ready held 0 for 10 cycles in RUN -> rng_out constant. en=0 with out_ready=1 -> no advance. acquire_seed during en=0 -> loads.
- STEPS=8, seed=1 -> one accept yields the same value as 8 accepts with STEPS=1 (compare against a bench reference model over 1000 words). acquire_seed and an accept in the same cycle -> load wins.
- WIDTH=16, TAPS=16'hB400 (x^16+x^14+x^13+x^11), seed=1: free-running accepts return to 0x0001 after exactly 65535 words, never 0. Async reset asserted mid-WARM -> immediate RESET_SEED, warm-up restarts.
